// File: rtl/hazard_tag_pipe_pkg.sv
// Shared encodings and the pipeline write-tag type for the GRF hazard/forwarding protocol.
// The optional mult/div busy tracking is enabled with the MDU_BUSY_EN macro.
package hazard_tag_pipe_pkg;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;

  localparam logic [1:0] GRFWDST_ALU = 2'd0;
  localparam logic [1:0] GRFWDST_DM  = 2'd1;
  localparam logic [1:0] GRFWDST_PC8 = 2'd2;

  typedef struct packed {
    logic [4:0] wreg;
    logic       wen;
    logic [1:0] wdst;
    logic [1:0] tnew;
  } tag_t;

  localparam int unsigned TagW = $bits(tag_t);

  // One stage older: the result is one cycle closer, never below zero.
  function automatic logic [1:0] tnew_age(input logic [1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_tag_pipe_stage_tag_reg.sv
// One pipeline write-tag register; optionally ages tnew on load, and loads an all-zero
// bubble when asked.
module stage_tag_reg
  import hazard_tag_pipe_pkg::*;
#(
  parameter bit Age = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bubble_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t tag_d, tag_q;

  always_comb begin
    tag_d = tag_i;
    if (Age) begin
      tag_d.tnew = tnew_age(tag_i.tnew);
    end
    if (bubble_i) begin
      tag_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/hazard_tag_pipe.sv
// Carries write tags D->E->M->W and produces the D-stage stall from tuse/tnew compares.
// Define MDU_BUSY_EN to add the mult/div busy counter that stalls HI/LO users.
module hazard_tag_pipe
  import hazard_tag_pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Drreg1,
  input  logic [4:0] Drreg2,
  input  logic [1:0] Dtuse1,
  input  logic [1:0] Dtuse2,
  input  logic [4:0] Dwreg,
  input  logic       DGRFwen,
  input  logic [1:0] DGRFwdst,
  input  logic [1:0] Dtnew,
  input  logic       Dmdstart,
  input  logic       Dmddiv,
  input  logic       Dmduse,
  output logic [4:0] Ewreg,
  output logic       EGRFwen,
  output logic [1:0] EGRFwdst,
  output logic [1:0] Etnew,
  output logic [4:0] Mwreg,
  output logic       MGRFwen,
  output logic [1:0] MGRFwdst,
  output logic [1:0] Mtnew,
  output logic [4:0] Wwreg,
  output logic       WGRFwen,
  output logic [1:0] WGRFwdst,
  output logic [1:0] Wtnew,
  output logic       stall,
  output logic       mdbusy
);

  tag_t d_tag, e_tag, m_tag, w_tag;
  logic mdstall;

  assign d_tag = '{wreg: Dwreg, wen: DGRFwen, wdst: DGRFwdst, tnew: Dtnew};

  // W is not checked: its tnew is always 0, so it can always forward.
  function automatic logic hit(input logic [4:0] r, input logic [1:0] tuse,
                               input tag_t e, input tag_t m);
    return (r != 5'd0) &&
           ((e.wen && e.wreg == r && e.tnew > tuse) ||
            (m.wen && m.wreg == r && m.tnew > tuse));
  endfunction

  assign stall = hit(Drreg1, Dtuse1, e_tag, m_tag) | hit(Drreg2, Dtuse2, e_tag, m_tag) | mdstall;

  // E takes Dtnew as-is since tnew is counted from E entry.
  stage_tag_reg #(.Age(1'b0)) u_e (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (stall),
    .tag_i    (d_tag),
    .tag_o    (e_tag)
  );

  stage_tag_reg #(.Age(1'b1)) u_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .tag_i    (e_tag),
    .tag_o    (m_tag)
  );

  stage_tag_reg #(.Age(1'b1)) u_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .tag_i    (m_tag),
    .tag_o    (w_tag)
  );

`ifdef MDU_BUSY_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (Dmdstart && !stall) begin
      cnt_d = Dmddiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mdbusy  = (cnt_q != '0);
  assign mdstall = Dmduse && mdbusy;
`else
  logic             unused_md;
  logic [CNT_W-1:0] unused_cyc;
  assign unused_md  = ^{Dmdstart, Dmddiv, Dmduse};
  assign unused_cyc = CNT_W'(MULT_CYCLES ^ DIV_CYCLES);
  assign mdbusy     = 1'b0;
  assign mdstall    = 1'b0;
`endif

  assign Ewreg    = e_tag.wreg;
  assign EGRFwen  = e_tag.wen;
  assign EGRFwdst = e_tag.wdst;
  assign Etnew    = e_tag.tnew;
  assign Mwreg    = m_tag.wreg;
  assign MGRFwen  = m_tag.wen;
  assign MGRFwdst = m_tag.wdst;
  assign Mtnew    = m_tag.tnew;
  assign Wwreg    = w_tag.wreg;
  assign WGRFwen  = w_tag.wen;
  assign WGRFwdst = w_tag.wdst;
  assign Wtnew    = w_tag.tnew;

endmodule

// File: tb/tb_hazard_tag_pipe.sv
// Directed bench for hazard_tag_pipe: reset, load-use stalls, $0/wen=0 immunity, mid-stall reset,
// and the MDU busy stall when MDU_BUSY_EN is defined.
module tb_hazard_tag_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Drreg1, Drreg2, Dwreg;
  logic [1:0] Dtuse1, Dtuse2, DGRFwdst, Dtnew;
  logic       DGRFwen, Dmdstart, Dmddiv, Dmduse;
  logic [4:0] Ewreg, Mwreg, Wwreg;
  logic       EGRFwen, MGRFwen, WGRFwen;
  logic [1:0] EGRFwdst, MGRFwdst, WGRFwdst, Etnew, Mtnew, Wtnew;
  logic       stall, mdbusy;

  int n_cmp = 0;
  int n_err = 0;

  hazard_tag_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Drreg1   (Drreg1),
    .Drreg2   (Drreg2),
    .Dtuse1   (Dtuse1),
    .Dtuse2   (Dtuse2),
    .Dwreg    (Dwreg),
    .DGRFwen  (DGRFwen),
    .DGRFwdst (DGRFwdst),
    .Dtnew    (Dtnew),
    .Dmdstart (Dmdstart),
    .Dmddiv   (Dmddiv),
    .Dmduse   (Dmduse),
    .Ewreg    (Ewreg),
    .EGRFwen  (EGRFwen),
    .EGRFwdst (EGRFwdst),
    .Etnew    (Etnew),
    .Mwreg    (Mwreg),
    .MGRFwen  (MGRFwen),
    .MGRFwdst (MGRFwdst),
    .Mtnew    (Mtnew),
    .Wwreg    (Wwreg),
    .WGRFwen  (WGRFwen),
    .WGRFwdst (WGRFwdst),
    .Wtnew    (Wtnew),
    .stall    (stall),
    .mdbusy   (mdbusy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive a full D-stage instruction, then let combinational outputs settle.
  task automatic set_d(input logic [4:0] r1, input logic [1:0] u1, input logic [4:0] r2,
                       input logic [1:0] u2, input logic [4:0] wr, input logic wen,
                       input logic [1:0] wdst, input logic [1:0] tn,
                       input logic mds, input logic mdd, input logic mdu);
    Drreg1 = r1; Dtuse1 = u1; Drreg2 = r2; Dtuse2 = u2;
    Dwreg = wr; DGRFwen = wen; DGRFwdst = wdst; Dtnew = tn;
    Dmdstart = mds; Dmddiv = mdd; Dmduse = mdu;
    #1;
  endtask

  task automatic nop();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    nop();
    repeat (4) step();
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    #12;
    // Reset state
    check_eq("rst_ewreg", Ewreg, 0);
    check_eq("rst_etnew", Etnew, 0);
    check_eq("rst_mwreg", Mwreg, 0);
    check_eq("rst_wwen", WGRFwen, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_mdbusy", mdbusy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_stall", stall, 0);
    check_eq("post_rst_etag", {Ewreg, EGRFwen, Etnew}, 0);

    // lw $t0 then add using $t0 (tuse 1): one stall cycle
    set_d(5'd29, 2'd1, 5'd0, 2'd0, 5'd8, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    check_eq("lw_d_nostall", stall, 0);
    step();
    check_eq("lw_e_wreg", Ewreg, 8);
    check_eq("lw_e_tnew", Etnew, 2);
    check_eq("lw_e_wdst", EGRFwdst, 1);
    set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd10, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
    check_eq("add_stall", stall, 1);
    step();
    check_eq("add_bubble_wen", EGRFwen, 0);
    check_eq("add_bubble_wreg", Ewreg, 0);
    check_eq("add_m_wreg", Mwreg, 8);
    check_eq("add_m_tnew", Mtnew, 1);
    check_eq("add_stall_drop", stall, 0);
    step();
    check_eq("add_e_wreg", Ewreg, 10);
    check_eq("add_e_tnew", Etnew, 1);
    check_eq("add_w_wreg", Wwreg, 8);
    check_eq("add_w_tnew", Wtnew, 0);
    flush();

    // lw $t0 then beq using $t0 (tuse 0): two stall cycles
    set_d(5'd29, 2'd1, 5'd0, 2'd0, 5'd8, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    set_d(5'd8, 2'd0, 5'd9, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("beq_stall1", stall, 1);
    step();
    check_eq("beq_stall2", stall, 1);
    check_eq("beq_m_tnew", Mtnew, 1);
    check_eq("beq_e_bubble", EGRFwen, 0);
    step();
    check_eq("beq_stall_drop", stall, 0);
    check_eq("beq_m_tnew0", Mtnew, 0);
    check_eq("beq_w_wreg", Wwreg, 8);
    check_eq("beq_w_tnew", Wtnew, 0);
    check_eq("beq_w_wen", WGRFwen, 1);
    flush();

    // Writes to $0 and wen=0 producers never stall
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd9, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    check_eq("r0_nostall", stall, 0);
    step();
    set_d(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("wen0_nostall", stall, 0);
    check_eq("wen0_e_wreg", Ewreg, 9);
    flush();

    // PC+8 link write tag passes through unchanged
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd31, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    nop();
    step();
    check_eq("jal_m_wdst", MGRFwdst, 2);
    check_eq("jal_m_wreg", Mwreg, 31);
    flush();

    // Reset asserted during the beq stall
    set_d(5'd29, 2'd1, 5'd0, 2'd0, 5'd8, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    step();
    set_d(5'd0, 2'd0, 5'd8, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid_pre", stall, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_stall", stall, 0);
    check_eq("rst_mid_ewreg", Ewreg, 0);
    check_eq("rst_mid_etnew", Etnew, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flush();

`ifdef MDU_BUSY_EN
    // mult then mfhi: 5 stall cycles; div: 10
    for (int k = 0; k < 2; k++) begin
      automatic int cyc = (k == 0) ? 5 : 10;
      set_d(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, k[0], 1'b1);
      check_eq("md_start_nostall", stall, 0);
      step();
      set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd8, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < cyc; i++) begin
        check_eq("md_stall", stall, 1);
        check_eq("md_busy", mdbusy, 1);
        step();
      end
      check_eq("md_stall_end", stall, 0);
      check_eq("md_busy_end", mdbusy, 0);
      flush();
    end
`else
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    step();
    check_eq("md_off_stall", stall, 0);
    check_eq("md_off_busy", mdbusy, 0);
    flush();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
